// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the FIFO word packer and its output buffer.
package fifo_pkg;
   localparam int DEF_IN_W  = 16;
   localparam int DEF_PACK  = 2;
   localparam int DEF_CNT_W = 16;

   typedef enum logic [2:0] {IDLE, RUN, DRAIN, EMIT, DONE} pk_state_e;
   typedef logic [DEF_IN_W-1:0] word_t;
endpackage

// File: rtl/beat_skid_buf.sv
// Two-entry output buffer for packed beats; the head entry drives the stream
// directly and stays stable while the sink stalls.
module beat_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_W = 2 * DEF_IN_W,
   parameter int KEEP_W = DEF_PACK
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic [KEEP_W-1:0] push_keep,
   input  logic              pop_ready,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [KEEP_W-1:0] keep,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] tail_data;
   logic [KEEP_W-1:0] tail_keep;
   logic              pop;

   assign valid = (count != 2'd0);
   assign pop   = valid && pop_ready;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data      <= '0;
         keep      <= '0;
         tail_data <= '0;
         tail_keep <= '0;
         count     <= 2'd0;
      end else begin
         case (count)
            2'd0: begin
               if (push) begin
                  data  <= push_data;
                  keep  <= push_keep;
                  count <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  data <= push_data;
                  keep <= push_keep;
               end else if (push) begin
                  tail_data <= push_data;
                  tail_keep <= push_keep;
                  count     <= 2'd2;
               end else if (pop) begin
                  count <= 2'd0;
               end
            end
            default: begin
               // Full: the upstream credit rule never pushes here without a pop.
               if (pop) begin
                  data <= tail_data;
                  keep <= tail_keep;
                  if (push) begin
                     tail_data <= push_data;
                     tail_keep <= push_keep;
                  end else begin
                     count <= 2'd1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/fifo_word_packer.sv
// Pops words from a sync_fifo (1-cycle read latency), packs PACK words per wide
// beat onto a valid/ready stream, and can flush a partial beat with lane keeps.
module fifo_word_packer
   import fifo_pkg::*;
#(
   parameter  int IN_W  = DEF_IN_W,
   parameter  int PACK  = DEF_PACK,
   parameter  int CNT_W = DEF_CNT_W,
   localparam int OUT_W = IN_W * PACK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             flush,
   input  logic             fifo_empty,
   input  logic [IN_W-1:0]  fifo_dout,
   output logic             fifo_rd_en,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [OUT_W-1:0] m_data,
   output logic [PACK-1:0]  m_keep,
   output logic             flush_done,
   output logic [CNT_W-1:0] beat_count,
   output logic             busy
);

   localparam int PC_W   = $clog2(PACK + 1);
   localparam int USED_W = 8;

   pk_state_e                   state, state_nxt;
   logic [PC_W-1:0]             pack_cnt;
   logic                        rd_pending;
   logic [PACK-1:0][IN_W-1:0]   lanes;
   logic [1:0]                  obuf_cnt;
   logic [USED_W-1:0]           used;
   logic                        last_word;
   logic                        emit_push;
   logic                        push;
   logic [PACK-1:0][IN_W-1:0]   full_beat;
   logic [PACK-1:0][IN_W-1:0]   part_beat;
   logic [PACK-1:0]             part_keep;
   logic [OUT_W-1:0]            push_data;
   logic [PACK-1:0]             push_keep;

   // Words already committed: buffered beats, lanes filled, and a read in flight.
   assign used = USED_W'(obuf_cnt) * USED_W'(PACK) + USED_W'(pack_cnt) + USED_W'(rd_pending);
   assign last_word = rd_pending && (pack_cnt == PC_W'(PACK - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (flush) state_nxt = DRAIN;
                  else if (enable) state_nxt = RUN;
         RUN:     if (flush) state_nxt = DRAIN;
                  else if (!enable) state_nxt = IDLE;
         DRAIN:   if (!rd_pending) state_nxt = (pack_cnt != '0) ? EMIT : DONE;
         EMIT:    if (obuf_cnt != 2'd2) state_nxt = DONE;
         DONE:    state_nxt = enable ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      fifo_rd_en = (state == RUN) && !fifo_empty && (used < USED_W'(2 * PACK));
      flush_done = (state == DONE);
      emit_push  = (state == EMIT) && (obuf_cnt != 2'd2);
   end

   always_comb begin
      full_beat           = lanes;
      full_beat[PACK-1]   = fifo_dout;
      part_beat           = '0;
      part_keep           = '0;
      for (int i = 0; i < PACK; i++) begin
         if (PC_W'(i) < pack_cnt) begin
            part_beat[i] = lanes[i];
            part_keep[i] = 1'b1;
         end
      end
      push      = last_word || emit_push;
      push_data = emit_push ? OUT_W'(part_beat) : OUT_W'(full_beat);
      push_keep = emit_push ? part_keep : '1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pending <= 1'b0;
         pack_cnt   <= '0;
         beat_count <= '0;
      end else begin
         rd_pending <= fifo_rd_en && !fifo_empty;
         if (rd_pending)     pack_cnt <= last_word ? '0 : pack_cnt + 1'b1;
         else if (emit_push) pack_cnt <= '0;
         if (m_valid && m_ready) beat_count <= beat_count + 1'b1;
      end
   end

   // NOTE: lane storage is data-only and always qualified by pack_cnt, so it
   // carries no reset.
   always_ff @(posedge clk) begin
      if (rd_pending) begin
         for (int i = 0; i < PACK; i++) begin
            if (pack_cnt == PC_W'(i)) lanes[i] <= fifo_dout;
         end
      end
   end

   beat_skid_buf #(
      .DATA_W (OUT_W),
      .KEEP_W (PACK)
   ) u_obuf (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .push_keep (push_keep),
      .pop_ready (m_ready),
      .valid     (m_valid),
      .data      (m_data),
      .keep      (m_keep),
      .count     (obuf_cnt)
   );

   assign busy = (state != IDLE) || (pack_cnt != '0) || rd_pending || (obuf_cnt != 2'd0);

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer with a behavioural sync_fifo model and a
// narrow-counter instance for beat_count wrap.
module tb_fifo_word_packer;
   import fifo_pkg::*;

   localparam int IN_W  = 16;
   localparam int PACK  = 2;
   localparam int OUT_W = IN_W * PACK;

   typedef struct {
      logic [OUT_W-1:0] data;
      logic [PACK-1:0]  keep;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst, enable, flush, fifo_empty, fifo_rd_en;
   logic             m_valid, m_ready, flush_done, busy;
   word_t            fifo_dout;
   logic [OUT_W-1:0] m_data;
   logic [PACK-1:0]  m_keep;
   logic [15:0]      beat_count;

   logic             w_en, w_rd_en, w_valid, w_fd, w_busy;
   logic [OUT_W-1:0] w_data;
   logic [PACK-1:0]  w_keep;
   logic [3:0]       w_count;

   word_t  fq[$];
   beat_t  exp_q[$];
   int     checks   = 0;
   int     failures = 0;
   int     pops     = 0;
   int     fd_cnt   = 0;
   int     w_beats  = 0;
   logic   fd_mvalid = 1'b0;
   logic [15:0] model_bc = '0;
   logic [3:0]  wrap_model = '0;

   fifo_word_packer u_dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .flush      (flush),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_keep     (m_keep),
      .flush_done (flush_done),
      .beat_count (beat_count),
      .busy       (busy)
   );

   fifo_word_packer #(.CNT_W(4)) u_wrap (
      .clk        (clk),
      .rst        (rst),
      .enable     (w_en),
      .flush      (1'b0),
      .fifo_empty (1'b0),
      .fifo_dout  (16'h5A5A),
      .fifo_rd_en (w_rd_en),
      .m_valid    (w_valid),
      .m_ready    (1'b1),
      .m_data     (w_data),
      .m_keep     (w_keep),
      .flush_done (w_fd),
      .beat_count (w_count),
      .busy       (w_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic load(input word_t w);
      fq.push_back(w);
      fifo_empty = 1'b0;
   endtask

   task automatic expect_beat(input logic [OUT_W-1:0] d, input logic [PACK-1:0] k);
      beat_t b;
      b.data = d;
      b.keep = k;
      exp_q.push_back(b);
   endtask

   // One clock: sample outputs at the falling edge, then model the FIFO read.
   task automatic tick();
      beat_t e;
      logic  pop;
      @(negedge clk);
      if (m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(m_data), 64'hDEAD_0000_0000_0000);
         end else begin
            e = exp_q.pop_front();
            check("beat_data", 64'(m_data), 64'(e.data));
            check("beat_keep", 64'(m_keep), 64'(e.keep));
         end
         check("beat_count_run", 64'(beat_count), 64'(model_bc));
         model_bc = model_bc + 16'd1;
      end
      if (w_valid) begin
         check("wrap_count", 64'(w_count), 64'(wrap_model));
         wrap_model = wrap_model + 4'd1;
         w_beats++;
      end
      if (flush_done) begin
         fd_cnt++;
         fd_mvalid = m_valid;
      end
      pop = fifo_rd_en && !fifo_empty;
      if (pop) pops++;
      @(posedge clk);
      #1;
      if (pop) fifo_dout = fq.pop_front();
      fifo_empty = (fq.size() == 0);
   endtask

   task automatic drain(input int budget, input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_drain_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      enable     = 1'b0;
      flush      = 1'b0;
      fifo_empty = 1'b1;
      fifo_dout  = '0;
      m_ready    = 1'b1;
      w_en       = 1'b0;
      #2;
      check("rst_valid", 64'(m_valid), 64'd0);
      check("rst_data",  64'(m_data),  64'd0);
      check("rst_keep",  64'(m_keep),  64'd0);
      check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
      check("rst_bc",    64'(beat_count), 64'd0);
      check("rst_busy",  64'(busy), 64'd0);
      check("rst_fdone", 64'(flush_done), 64'd0);
      #5 rst = 1'b0;

      // Four words, sink always ready.
      enable = 1'b1;
      load(16'h1111); load(16'h2222); load(16'h3333); load(16'h4444);
      expect_beat(32'h2222_1111, 2'b11);
      expect_beat(32'h4444_3333, 2'b11);
      drain(30, "t1");
      tick(); tick();
      check("t1_rd_en_empty", 64'(fifo_rd_en), 64'd0);
      check("t1_beat_count",  64'(beat_count), 64'd2);

      // Stalled sink: credits allow exactly two buffered beats.
      m_ready = 1'b0;
      pops = 0;
      for (int i = 0; i < 10; i++) load(word_t'(16'h1000 + i));
      for (int i = 0; i < 10; i += 2)
         expect_beat({word_t'(16'h1000 + i + 1), word_t'(16'h1000 + i)}, 2'b11);
      repeat (12) tick();
      check("t2_pops",   64'(pops), 64'd4);
      check("t2_rd_en",  64'(fifo_rd_en), 64'd0);
      check("t2_valid",  64'(m_valid), 64'd1);
      check("t2_head",   64'(m_data), 64'h1001_1000);
      repeat (3) tick();
      check("t2_head_stable", 64'(m_data), 64'h1001_1000);
      m_ready = 1'b1;
      drain(40, "t2");
      check("t2_beat_count", 64'(beat_count), 64'd7);

      // Three words then flush; a word arriving during the flush is not popped.
      load(16'h000A); load(16'h000B); load(16'h000C);
      expect_beat(32'h000B_000A, 2'b11);
      expect_beat(32'h0000_000C, 2'b01);
      repeat (8) tick();
      check("t3_busy_partial", 64'(busy), 64'd1);
      pops   = 0;
      fd_cnt = 0;
      flush  = 1'b1;
      enable = 1'b0;
      tick();
      flush = 1'b0;
      load(16'h000D);
      repeat (10) tick();
      check("t3_no_pops",    64'(pops), 64'd0);
      check("t3_fdone_once", 64'(fd_cnt), 64'd1);
      check("t3_left",       64'(exp_q.size()), 64'd0);
      check("t3_idle",       64'(busy), 64'd0);
      check("t3_beat_count", 64'(beat_count), 64'd9);

      // Flush in the same cycle as a pop: the popped word lands in the final beat.
      pops   = 0;
      fd_cnt = 0;
      fd_mvalid = 1'b0;
      expect_beat(32'h0000_000D, 2'b01);
      enable = 1'b1;
      tick();
      check("t4_rd_en", 64'(fifo_rd_en), 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      repeat (10) tick();
      check("t4_pops",       64'(pops), 64'd1);
      check("t4_fdone_once", 64'(fd_cnt), 64'd1);
      check("t4_beat_before_done", 64'(fd_mvalid), 64'd1);
      check("t4_left",       64'(exp_q.size()), 64'd0);
      check("t4_beat_count", 64'(beat_count), 64'd10);
      enable = 1'b0;
      tick(); tick();
      check("t4_idle", 64'(busy), 64'd0);

      // Asynchronous reset with the output buffer full.
      m_ready = 1'b0;
      enable  = 1'b1;
      for (int i = 0; i < 6; i++) load(word_t'(16'h2000 + i));
      repeat (8) tick();
      check("t5_valid_pre", 64'(m_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("t5_valid", 64'(m_valid), 64'd0);
      check("t5_data",  64'(m_data), 64'd0);
      check("t5_keep",  64'(m_keep), 64'd0);
      check("t5_bc",    64'(beat_count), 64'd0);
      check("t5_rd_en", 64'(fifo_rd_en), 64'd0);
      check("t5_busy",  64'(busy), 64'd0);
      fq.delete();
      exp_q.delete();
      fifo_empty = 1'b1;
      fifo_dout  = '0;
      model_bc   = '0;
      wrap_model = '0;
      #2 rst = 1'b0;
      m_ready = 1'b1;
      load(16'hBEEF); load(16'hCAFE);
      expect_beat(32'hCAFE_BEEF, 2'b11);
      drain(30, "t5");
      check("t5_beat_count", 64'(beat_count), 64'd1);
      enable = 1'b0;
      tick(); tick();

      // Counter wrap on a 4-bit beat_count instance.
      w_beats = 0;
      w_en = 1'b1;
      repeat (45) tick();
      w_en = 1'b0;
      check("wrap_passed", 64'(w_beats >= 17), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
